pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//   Sequences the program counter register and the instruction-memory fetch handshake.
//   Picks next PC with priority trap > redirect > stall > sequential (pc+4).
//   Sits between PC register and imem port; drives decode with (pc, valid).
//   Keeps an outstanding imem request stable until acked, even if a redirect arrives mid-flight.
// PARAMETERS
//   XLEN       32            address/PC width
//   RESET_VEC  32'h0000_0000 PC loaded on reset
//   TRAP_VEC   32'h0000_0100 PC loaded on trap or misaligned redirect
// PORTS
//   clk               in   1     rising-edge clock
//   rst               in   1     asynchronous, active-high reset
//   stall_i           in   1     downstream not ready; hold current pc/valid
//   redirect_valid_i  in   1     branch/jump taken this cycle
//   redirect_pc_i     in   XLEN  branch/jump target
//   trap_i            in   1     exception/interrupt; highest priority
//   imem_req_o        out  1     fetch request, held until imem_ack_i
//   imem_addr_o       out  XLEN  fetch address, stable while imem_req_o=1
//   imem_ack_i        in   1     imem accepted request and returned instruction
//   pc_o              out  XLEN  PC of instruction presented to decode
//   pc_valid_o        out  1     pc_o carries a valid fetched instruction
//   misalign_o        out  1     1-cycle pulse: redirect target had [1:0]!=0
// BEHAVIOUR
//   Reset (async assert, sync to next edge on release): state=BOOT, fetch_pc=RESET_VEC,
//     pc_o=RESET_VEC, imem_req_o=0, imem_addr_o=RESET_VEC, pc_valid_o=0, misalign_o=0, pend=0.
//   States: BOOT -> FETCH (unconditional, 1 cycle); FETCH <-> HOLD.
//   FETCH: imem_req_o=1, imem_addr_o=fetch_pc. No ack -> stay, addr unchanged.
//     On ack, no pend, no stall_i: pc_o<=fetch_pc, pc_valid_o<=1, fetch_pc<=next.
//     On ack with stall_i=1: -> HOLD; fetched pc latched, pc_valid_o<=1, fetch_pc not advanced.
//   HOLD: imem_req_o=0; pc_o, pc_valid_o frozen; stall_i=0 -> FETCH with fetch_pc+4.
//   Next-PC selection (evaluated every cycle):
//     trap_i            -> TRAP_VEC
//     redirect_valid_i  -> redirect_pc_i; if redirect_pc_i[1:0]!=0: TRAP_VEC, misalign_o=1
//     otherwise         -> fetch_pc + 4, modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000)
//   Trap/redirect while imem_req_o=1 and no ack: latch target into pend_pc, pend=1;
//     request/addr unchanged; on ack, returned instruction discarded (pc_valid_o=0),
//     fetch_pc<=pend_pc, pend<=0. Newer trap/redirect overwrites pend_pc (same priority).
//   Trap/redirect coincident with ack: target taken directly, fetched instr discarded.
//   Trap/redirect in HOLD: pc_valid_o<=0, fetch_pc<=target, -> FETCH (stall ignored for flush).
//   pc_valid_o is a registered output; latency request-ack -> pc_valid_o = 1 cycle.
//   misalign_o high exactly one cycle per offending redirect; trap_i masks it.
//   Reset asserted mid-fetch: request dropped immediately, all state to reset values.
// STRUCTURE
//   Package pc_seq_pkg: state encoding (BOOT=2'd0, FETCH=2'd1, HOLD=2'd2),
//     INSTR_BYTES=4, ALIGN_MASK=2'b11.
//   Sub-module pc_next_sel: combinational priority mux (trap/redirect/seq + misalign detect).
//   Top holds FSM, fetch_pc, pend/pend_pc, output registers.
// TESTING
//   1 Reset, ack every cycle -> pc_o 0,4,8,12 with pc_valid_o=1 from 2nd cycle after release.
//   2 Hold imem_ack_i low 3 cycles at addr 8 -> imem_addr_o stays 8, pc_valid_o=0, then pc_o=8.
//   3 redirect to 0x40 while ack pending at addr 12 -> addr holds 12; on ack valid=0; next fetch 0x40.
//   4 redirect to 0x42 -> misalign_o one pulse, next fetch addr 0x100.
//   5 trap_i and redirect(0x80) same cycle -> next fetch 0x100; stall 2 cycles -> pc_o/valid frozen.
//   6 fetch_pc=0xFFFF_FFFC, ack -> next addr 0x0; assert rst mid-request -> imem_req_o=0 same cycle.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the PC fetch sequencer.
//   state_t     - FSM encoding (BOOT, FETCH, HOLD)
//   INSTR_BYTES - sequential PC increment
//   ALIGN_MASK  - low PC bits that must be zero for a legal target
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int         INSTR_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux.
//   fetch_pc       in   current fetch address
//   trap           in   exception/interrupt (highest priority)
//   redirect_valid in   branch/jump taken
//   redirect_pc    in   branch/jump target
//   next_pc        out  selected next fetch address
//   flush          out  trap or redirect present (sequential flow broken)
//   misalign       out  redirect target misaligned and not masked by trap
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            trap,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            flush,
    output logic            misalign
);

    logic target_bad;
    assign target_bad = |(redirect_pc[1:0] & ALIGN_MASK);

    always_comb begin
        next_pc  = fetch_pc + XLEN'(INSTR_BYTES);  // wraps modulo 2^XLEN
        flush    = trap | redirect_valid;
        misalign = 1'b0;
        if (trap) begin
            next_pc = TRAP_VEC;
        end else if (redirect_valid) begin
            // A misaligned target is steered to the trap vector
            next_pc  = target_bad ? TRAP_VEC : redirect_pc;
            misalign = target_bad;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC register and imem fetch handshake sequencer.
//   clk, rst          clock, async active-high reset
//   stall_i           downstream not ready; hold pc/valid
//   redirect_valid_i  branch/jump taken, target redirect_pc_i
//   trap_i            exception/interrupt, highest priority
//   imem_req_o        fetch request, held until imem_ack_i
//   imem_addr_o       fetch address, stable while imem_req_o=1
//   imem_ack_i        imem accepted request and returned instruction
//   pc_o, pc_valid_o  PC presented to decode and its valid flag
//   misalign_o        one-cycle pulse on a misaligned redirect target
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            misalign_o
);

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pend_pc;
    logic            pend;

    logic [XLEN-1:0] next_pc;
    logic            flush;
    logic            sel_misalign;

    pc_next_sel #(.XLEN(XLEN), .TRAP_VEC(TRAP_VEC)) u_next_sel (
        .fetch_pc      (fetch_pc),
        .trap          (trap_i),
        .redirect_valid(redirect_valid_i),
        .redirect_pc   (redirect_pc_i),
        .next_pc       (next_pc),
        .flush         (flush),
        .misalign      (sel_misalign)
    );

    // The request address is the fetch_pc register itself, so it cannot
    // move while a request is outstanding: fetch_pc only changes on ack.
    assign imem_addr_o = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            fetch_pc   <= RESET_VEC;
            pend_pc    <= RESET_VEC;
            pend       <= 1'b0;
            pc_o       <= RESET_VEC;
            pc_valid_o <= 1'b0;
            imem_req_o <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= sel_misalign;
            case (state)
                BOOT: begin
                    if (flush) fetch_pc <= next_pc;
                    state      <= FETCH;
                    imem_req_o <= 1'b1;
                end
                FETCH: begin
                    if (!imem_ack_i) begin
                        pc_valid_o <= 1'b0;
                        // Remember the newest target; the live request stays put
                        if (flush) begin
                            pend    <= 1'b1;
                            pend_pc <= next_pc;
                        end
                    end else if (flush) begin
                        // Coincident flush wins over any older pending target
                        pc_valid_o <= 1'b0;
                        fetch_pc   <= next_pc;
                        pend       <= 1'b0;
                    end else if (pend) begin
                        pc_valid_o <= 1'b0;
                        fetch_pc   <= pend_pc;
                        pend       <= 1'b0;
                    end else if (stall_i) begin
                        pc_o       <= fetch_pc;
                        pc_valid_o <= 1'b1;
                        imem_req_o <= 1'b0;
                        state      <= HOLD;
                    end else begin
                        pc_o       <= fetch_pc;
                        pc_valid_o <= 1'b1;
                        fetch_pc   <= next_pc;
                    end
                end
                HOLD: begin
                    // Flush overrides stall; otherwise resume at the sequential pc
                    if (flush || !stall_i) begin
                        pc_valid_o <= 1'b0;
                        fetch_pc   <= next_pc;
                        imem_req_o <= 1'b1;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state      <= BOOT;
                    imem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        misalign_o;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .trap_i          (trap_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full output set in one call
    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic [31:0] pc, input logic vld, input logic mis);
        chk({tag, ".req"},  {31'd0, imem_req_o}, {31'd0, req});
        chk({tag, ".addr"}, imem_addr_o, addr);
        chk({tag, ".pc"},   pc_o, pc);
        chk({tag, ".vld"},  {31'd0, pc_valid_o}, {31'd0, vld});
        chk({tag, ".mis"},  {31'd0, misalign_o}, {31'd0, mis});
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        trap_i = 1'b0; imem_ack_i = 1'b0;
        step(); step();
        expect_out("reset", 0, 32'h0, 32'h0, 0, 0);
        rst = 1'b0;

        // 1: boot then ack every cycle
        step();
        expect_out("boot", 1, 32'h0, 32'h0, 0, 0);
        imem_ack_i = 1'b1;
        step(); expect_out("seq0", 1, 32'h4, 32'h0, 1, 0);
        step(); expect_out("seq4", 1, 32'h8, 32'h4, 1, 0);

        // 2: ack held low three cycles at addr 8
        imem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("wait8", 1, 32'h8, 32'h4, 0, 0);
        end
        imem_ack_i = 1'b1;
        step(); expect_out("seq8", 1, 32'hC, 32'h8, 1, 0);

        // 3: redirect while request at 12 is outstanding
        imem_ack_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
        step(); expect_out("pend", 1, 32'hC, 32'h8, 0, 0);
        redirect_valid_i = 1'b0; imem_ack_i = 1'b1;
        step(); expect_out("discard", 1, 32'h40, 32'h8, 0, 0);
        step(); expect_out("at40", 1, 32'h44, 32'h40, 1, 0);

        // 4: misaligned redirect coincident with ack
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h42;
        step(); expect_out("mis", 1, 32'h100, 32'h40, 0, 1);
        redirect_valid_i = 1'b0;
        step(); expect_out("mis_end", 1, 32'h104, 32'h100, 1, 0);

        // 5: trap + misaligned redirect same cycle, trap wins and masks misalign
        trap_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h82;
        step(); expect_out("trap", 1, 32'h100, 32'h100, 0, 0);
        trap_i = 1'b0; redirect_valid_i = 1'b0;
        step(); expect_out("at100", 1, 32'h104, 32'h100, 1, 0);
        stall_i = 1'b1;
        step(); expect_out("hold0", 0, 32'h104, 32'h104, 1, 0);
        step(); expect_out("hold1", 0, 32'h104, 32'h104, 1, 0);
        step(); expect_out("hold2", 0, 32'h104, 32'h104, 1, 0);
        stall_i = 1'b0;
        step(); expect_out("resume", 1, 32'h108, 32'h104, 0, 0);
        stall_i = 1'b1;
        step(); expect_out("hold3", 0, 32'h108, 32'h108, 1, 0);
        trap_i = 1'b1;
        step(); expect_out("holdtrap", 1, 32'h100, 32'h108, 0, 0);
        trap_i = 1'b0; stall_i = 1'b0;

        // 6: wrap at top of address space, then reset mid-request
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step(); expect_out("to_top", 1, 32'hFFFF_FFFC, 32'h108, 0, 0);
        redirect_valid_i = 1'b0;
        step(); expect_out("wrap", 1, 32'h0, 32'hFFFF_FFFC, 1, 0);
        imem_ack_i = 1'b0;
        step(); expect_out("req0", 1, 32'h0, 32'hFFFF_FFFC, 0, 0);
        #2 rst = 1'b1;
        #1 expect_out("rst_mid", 0, 32'h0, 32'h0, 0, 0);
        step();
        rst = 1'b0;
        step(); expect_out("reboot", 1, 32'h0, 32'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
